vga_color_line_gen: RTL and testbench
=====================================

Name: vga_color_line_gen

Overview:
- VGA 640x480@60 Hz timing generator with a solid-colour fill of the visible area.
- The 9-bit RGB input (3 bits per channel) is expanded to the 4-bit-per-channel VGA DAC outputs.
- Sits between system control logic (which selects the colour) and the board VGA connector.

Parameters:
- CLK_DIV, 4, system-clock cycles per pixel (100 MHz CLK -> 25 MHz pixel tick); must be >= 1.
- H_VISIBLE, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch in pixels.
- H_SYNC, 96, horizontal sync pulse width in pixels.
- H_BACK, 48, horizontal back porch in pixels.
- V_VISIBLE, 480, visible lines per frame.
- V_FRONT, 10, vertical front porch in lines.
- V_SYNC, 2, vertical sync pulse width in lines.
- V_BACK, 33, vertical back porch in lines.

Ports:
- CLK  in  1  system clock; all logic on its rising edge.
- RST_N  in  1  asynchronous, active-high reset (1 = reset asserted, despite the name).
- RGB  in  9  requested colour: [8:6] red, [5:3] green, [2:0] blue.
- VGA_HSYNC  out  1  horizontal sync, active low.
- VGA_VSYNC  out  1  vertical sync, active low.
- VGA_RED  out  4  red intensity.
- VGA_GREEN  out  4  green intensity.
- VGA_BLUE  out  4  blue intensity.

Behaviour:
- Reset (RST_N=1, asynchronous): divider, h_cnt and v_cnt = 0; VGA_HSYNC=1, VGA_VSYNC=1; all colour outputs = 0. Held while RST_N=1.
- Pixel tick: a divider counts 0..CLK_DIV-1 and pulses a tick when it wraps. With CLK_DIV=1, every cycle is a tick.
- h_cnt: advances on each tick over 0..H_TOTAL-1 (800) and wraps to 0.
- v_cnt: advances when h_cnt wraps, over 0..V_TOTAL-1 (525), and wraps to 0.
- Horizontal regions: visible h_cnt 0..639; hsync low for h_cnt in [656, 751].
- Vertical regions: visible v_cnt 0..479; vsync low for v_cnt in [490, 491].
- All outputs are registered and update only on a tick. Sync and colour are derived from the same counter value, so they stay mutually aligned with one tick of latency from counter to pins.
- Active area (h_cnt<640 and v_cnt<480): each output channel = {c[2:0], c[2]}, where c is the 3-bit field of RGB sampled on that tick.
  - Examples: 3'b111 -> 4'hF, 3'b100 -> 4'h9, 3'b000 -> 4'h0.
- Blanking (any non-active position): all colour outputs = 0 regardless of RGB.
- RGB changes take effect on the next active pixel tick. No frame-level latching.
- Reset asserted mid-frame: immediate return to reset values. After release, the first tick restarts at h_cnt=0, v_cnt=0.
- Line/frame period: 800 x CLK_DIV clocks per line; 420000 x CLK_DIV clocks per frame.

Decomposition:
- Shared package vga_pkg:
  - 640x480 timing constants and derived H_TOTAL/V_TOTAL, plus sync start/end values.
  - Function expand3to4 for the colour mapping.
- One natural sub-module, vga_timing: divider plus counters, producing tick, h_cnt, v_cnt, active, hsync_n, vsync_n.
- The top level adds the colour registers and the blanking mux.

Test Plan:
- Reset: assert RST_N=1 mid-frame -> all outputs return immediately to HSYNC=1, VSYNC=1, colours 0. Release -> the first visible pixel appears CLK_DIV clocks later.
- Sync timing (CLK_DIV=4):
  - HSYNC low for 384 clocks every 3200 clocks.
  - VSYNC low for 6400 clocks every 1 680 000 clocks.
  - HSYNC falls 2624 clocks after the line start.
- Colour mapping during active video:
  - RGB=9'h000 -> 0/0/0.
  - RGB=9'h0F0 -> R=4'h6, G=4'hD, B=4'h0.
  - RGB=9'h1FF -> F/F/F.
  - RGB=9'h1C0 -> R=F, G=0, B=0.
- Blanking: RGB=9'h1FF held -> colours are 0 for h_cnt 640..799 and for v_cnt 480..524.
- Mid-line colour change: switch RGB from 9'h000 to 9'h0F0 at pixel 100 -> the new colour appears at the next tick; sync timing is undisturbed.
- CLK_DIV=1 build: line period = 800 clocks; frame period = 420000 clocks.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared 640x480@60 Hz timing constants and the 3-bit to 4-bit colour expansion
// used by the VGA colour-fill generator.
package vga_pkg;

  localparam int CNT_W = 10;

  localparam int VGA_CLK_DIV   = 4;
  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;

  localparam int VGA_H_TOTAL = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_V_TOTAL = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  localparam int VGA_H_SYNC_START = VGA_H_VISIBLE + VGA_H_FRONT;
  localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;
  localparam int VGA_V_SYNC_START = VGA_V_VISIBLE + VGA_V_FRONT;
  localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

  // Replicating the MSB spreads 0..7 evenly over 0..15 (7 -> F, 4 -> 9).
  function automatic logic [3:0] expand3to4(input logic [2:0] c);
    return {c, c[2]};
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-tick divider plus horizontal/vertical counters; decodes the active area
// and the active-low sync windows from the current counter position.
module vga_timing
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = VGA_CLK_DIV,
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK
) (
  input  logic clk,
  input  logic rst,
  output logic tick,
  output logic active,
  output logic hsync_n,
  output logic vsync_n
);

  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC - 1;
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_last;
  logic             v_last;

  // With CLK_DIV=1 the divider sits at 0 and every cycle is a tick.
  assign tick   = (div == DIV_W'(CLK_DIV - 1));
  assign h_last = (h_cnt == CNT_W'(H_TOTAL - 1));
  assign v_last = (v_cnt == CNT_W'(V_TOTAL - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
    end else if (tick) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (tick) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + CNT_W'(1);
      end else begin
        h_cnt <= h_cnt + CNT_W'(1);
      end
    end
  end

  assign active  = (h_cnt < CNT_W'(H_VISIBLE)) && (v_cnt < CNT_W'(V_VISIBLE));
  assign hsync_n = !((h_cnt >= CNT_W'(HS_START)) && (h_cnt <= CNT_W'(HS_END)));
  assign vsync_n = !((v_cnt >= CNT_W'(VS_START)) && (v_cnt <= CNT_W'(VS_END)));

endmodule

// File: rtl/vga_color_line_gen.sv
// VGA 640x480 solid-colour generator: registers sync and blanked colour on each
// pixel tick so all pins change together, one tick after the counter position.
module vga_color_line_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = VGA_CLK_DIV,
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [8:0] RGB,
  output logic       VGA_HSYNC,
  output logic       VGA_VSYNC,
  output logic [3:0] VGA_RED,
  output logic [3:0] VGA_GREEN,
  output logic [3:0] VGA_BLUE
);

  logic tick;
  logic active;
  logic hsync_n;
  logic vsync_n;

  vga_timing #(
    .CLK_DIV  (CLK_DIV),
    .H_VISIBLE(H_VISIBLE),
    .H_FRONT  (H_FRONT),
    .H_SYNC   (H_SYNC),
    .H_BACK   (H_BACK),
    .V_VISIBLE(V_VISIBLE),
    .V_FRONT  (V_FRONT),
    .V_SYNC   (V_SYNC),
    .V_BACK   (V_BACK)
  ) u_timing (
    .clk    (CLK),
    .rst    (RST_N),
    .tick   (tick),
    .active (active),
    .hsync_n(hsync_n),
    .vsync_n(vsync_n)
  );

  // RST_N is active-high despite its name.
  always_ff @(posedge CLK or posedge RST_N) begin
    if (RST_N) begin
      VGA_HSYNC <= 1'b1;
      VGA_VSYNC <= 1'b1;
      VGA_RED   <= 4'h0;
      VGA_GREEN <= 4'h0;
      VGA_BLUE  <= 4'h0;
    end else if (tick) begin
      VGA_HSYNC <= hsync_n;
      VGA_VSYNC <= vsync_n;
      VGA_RED   <= active ? expand3to4(RGB[8:6]) : 4'h0;
      VGA_GREEN <= active ? expand3to4(RGB[5:3]) : 4'h0;
      VGA_BLUE  <= active ? expand3to4(RGB[2:0]) : 4'h0;
    end
  end

endmodule

// File: tb/tb_vga_color_line_gen.sv
// Directed bench: default-timing DUT (CLK_DIV=4), a CLK_DIV=1 default-timing DUT
// and a CLK_DIV=1 DUT with a tiny raster so whole frames fit in a short run.
module tb_vga_color_line_gen;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [8:0] rgb_m, rgb_s, rgb_1;
  int         cyc;
  int         n_tests = 0;
  int         n_fail  = 0;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // ---------------- DUTs ----------------
  logic       hs_m, vs_m, hs_s, vs_s, hs_1, vs_1;
  logic [3:0] r_m, g_m, b_m, r_s, g_s, b_s, r_1, g_1, b_1;

  vga_color_line_gen dut (
    .CLK(clk), .RST_N(rst), .RGB(rgb_m), .VGA_HSYNC(hs_m), .VGA_VSYNC(vs_m),
    .VGA_RED(r_m), .VGA_GREEN(g_m), .VGA_BLUE(b_m)
  );

  vga_color_line_gen #(
    .CLK_DIV(1), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) dut_s (
    .CLK(clk), .RST_N(rst), .RGB(rgb_s), .VGA_HSYNC(hs_s), .VGA_VSYNC(vs_s),
    .VGA_RED(r_s), .VGA_GREEN(g_s), .VGA_BLUE(b_s)
  );

  vga_color_line_gen #(.CLK_DIV(1)) dut_1 (
    .CLK(clk), .RST_N(rst), .RGB(rgb_1), .VGA_HSYNC(hs_1), .VGA_VSYNC(vs_1),
    .VGA_RED(r_1), .VGA_GREEN(g_1), .VGA_BLUE(b_1)
  );

  logic [14:0] o_m, o_s, o_1;
  assign o_m = {hs_m, vs_m, r_m, g_m, b_m};
  assign o_s = {hs_s, vs_s, r_s, g_s, b_s};
  assign o_1 = {hs_1, vs_1, r_1, g_1, b_1};

  // ---------------- sync edge monitor ----------------
  // index 3: dut hsync, 2: dut_s vsync, 1: dut_1 hsync, 0: dut vsync
  logic [3:0] sig, prev;
  int f0[4], r0[4], f1[4], nf[4];
  assign sig = {hs_m, vs_s, hs_1, vs_m};

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        nf[i] <= 0; f0[i] <= -1; r0[i] <= -1; f1[i] <= -1;
      end
      prev <= 4'hF;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (prev[i] && !sig[i]) begin
          if (nf[i] == 0) f0[i] <= cyc;
          else if (nf[i] == 1) f1[i] <= cyc;
          nf[i] <= nf[i] + 1;
        end
        if (!prev[i] && sig[i] && nf[i] == 1 && r0[i] < 0) r0[i] <= cyc;
      end
      prev <= sig;
    end
  end

  // ---------------- driver / checking tasks ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // cyc counts posedges since reset release; waits are bounded by the bench clock.
  task automatic at_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Pixel n of the CLK_DIV=4 DUT is on the pins for cyc 4(n+1)..4(n+1)+3.
  task automatic at_px_m(input int n);
    at_cyc(4 * n + 5);
  endtask

  function automatic logic [14:0] px(input bit hs, input bit vs, input logic [11:0] c);
    return {hs, vs, c};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    rgb_m = 9'h1FF;
    rgb_s = 9'h1FF;
    rgb_1 = 9'h1FF;
    repeat (3) @(negedge clk);
    check("reset_m", o_m, px(1, 1, 12'h000));
    check("reset_s", o_s, px(1, 1, 12'h000));
    check("reset_1", o_1, px(1, 1, 12'h000));
    rst = 1'b0;

    fork
      begin : thread_main
        at_px_m(0);   check("m_px0_fff", o_m, px(1, 1, 12'hFFF)); rgb_m = 9'h000;
        at_px_m(50);  check("m_px50_000", o_m, px(1, 1, 12'h000));
        at_px_m(99);  check("m_px99_000", o_m, px(1, 1, 12'h000)); rgb_m = 9'h0F0;
        at_px_m(100); check("m_px100_6d0", o_m, px(1, 1, 12'h6D0)); rgb_m = 9'h1C0;
        at_px_m(101); check("m_px101_f00", o_m, px(1, 1, 12'hF00)); rgb_m = 9'h1FF;
        at_px_m(639); check("m_px639_last", o_m, px(1, 1, 12'hFFF));
        at_px_m(640); check("m_px640_blank", o_m, px(1, 1, 12'h000));
        at_px_m(655); check("m_px655_pre_hs", o_m, px(1, 1, 12'h000));
        at_px_m(656); check("m_px656_hs", o_m, px(0, 1, 12'h000));
        at_px_m(751); check("m_px751_hs", o_m, px(0, 1, 12'h000));
        at_px_m(752); check("m_px752_post_hs", o_m, px(1, 1, 12'h000));
        at_px_m(799); check("m_px799_blank", o_m, px(1, 1, 12'h000));
        at_px_m(800); check("m_line1_px0", o_m, px(1, 1, 12'hFFF));
        at_px_m(1500); check("m_line1_hs", o_m, px(0, 1, 12'h000));
        check("m_hs_fall_2624", f0[3] - 4, 2624);
        check("m_hs_low_384", r0[3] - f0[3], 384);
        check("m_hs_period_3200", f1[3] - f0[3], 3200);
        check("m_vs_no_fall", nf[0], 0);
      end
      begin : thread_small
        at_cyc(8);   check("s_h7_last", o_s, px(1, 1, 12'hFFF));
        at_cyc(9);   check("s_h8_blank", o_s, px(1, 1, 12'h000));
        at_cyc(11);  check("s_h10_hs", o_s, px(0, 1, 12'h000));
        at_cyc(14);  check("s_h13_post_hs", o_s, px(1, 1, 12'h000));
        at_cyc(16);  check("s_v1_h0", o_s, px(1, 1, 12'hFFF));
        at_cyc(53);  check("s_v3_h7", o_s, px(1, 1, 12'hFFF));
        at_cyc(61);  check("s_v4_vblank", o_s, px(1, 1, 12'h000));
        at_cyc(76);  check("s_v5_vs", o_s, px(1, 0, 12'h000));
        at_cyc(101); check("s_v6_hs_vs", o_s, px(0, 0, 12'h000));
        at_cyc(106); check("s_v7_post_vs", o_s, px(1, 1, 12'h000));
        at_cyc(121); check("s_frame_wrap", o_s, px(1, 1, 12'hFFF));
        at_cyc(200);
        check("s_vs_fall", f0[2], 76);
        check("s_vs_low_30", r0[2] - f0[2], 30);
        check("s_frame_120", f1[2] - f0[2], 120);
      end
      begin : thread_div1
        at_cyc(640); check("d1_px639", o_1, px(1, 1, 12'hFFF));
        at_cyc(641); check("d1_px640", o_1, px(1, 1, 12'h000));
        at_cyc(1500);
        check("d1_hs_fall", f0[1], 657);
        check("d1_hs_low_96", r0[1] - f0[1], 96);
        check("d1_line_800", f1[1] - f0[1], 800);
      end
    join

    // Mid-frame reset while hsync is low: pins must drop back without a clock edge.
    rst = 1'b1;
    #1;
    check("rst_async", o_m, px(1, 1, 12'h000));
    repeat (3) @(negedge clk);
    check("rst_hold", o_m, px(1, 1, 12'h000));
    rst = 1'b0;
    at_cyc(3);    check("rel_pre_tick", o_m, px(1, 1, 12'h000));
    at_cyc(4);    check("rel_first_px", o_m, px(1, 1, 12'hFFF));
    at_cyc(2700); check("rel_hs_restart", f0[3], 2628);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
